// File: rtl/reg_file_wb.sv
// reg_file_wb
//   Register file at the receiving end of the writeback path. It stores the
//   selected writeback word (ALU result, load data or link address) into the
//   destination register on the rising clock edge. It serves two combinational
//   decode-stage read ports with same-cycle write-through bypass. A
//   per-register load scoreboard raises a load-use stall to the hazard unit.
//
// Ports
//   clk, rst            clock (rising edge) / asynchronous active-high reset
//   wb_en/num/data      writeback strobe, destination register, word
//   rs_num -> rs_data   read port A (combinational, bypassed)
//   rt_num -> rt_data   read port B (combinational, bypassed)
//   ld_issue, ld_num    a load entered execute, and its destination register
//   flush               drops all outstanding loads from the scoreboard
//   stall               load-use hazard on rs or rt (combinational)
//   ld_pending          number of registers currently marked busy
//   link_valid          LINK_REG has been written since reset (sticky)

module reg_file_wb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned LINK_REG = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_num,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] rs_num,
   input  logic [ADDR_W-1:0] rt_num,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              ld_issue,
   input  logic [ADDR_W-1:0] ld_num,
   input  logic              flush,
   output logic              stall,
   output logic [ADDR_W:0]   ld_pending,
   output logic              link_valid
);

   localparam int unsigned NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [ADDR_W:0]   ld_pending_q, ld_pending_d;
   logic              link_valid_q, link_valid_d;

   // Next-state: register write, scoreboard update, sticky link flag.
   always_comb begin
      regs_d       = regs_q;
      busy_d       = busy_q;
      link_valid_d = link_valid_q;
      ld_pending_d = '0;

      if (wb_en && wb_num != '0)
         regs_d[wb_num] = wb_data;

      // Clear first, then set: a load issued behind a completing one to the
      // same register keeps it busy. Flush overrides both.
      if (wb_en)
         busy_d[wb_num] = 1'b0;
      if (ld_issue && ld_num != '0)
         busy_d[ld_num] = 1'b1;
      if (flush)
         busy_d = '0;

      if (wb_en && wb_num == ADDR_W'(LINK_REG))
         link_valid_d = 1'b1;

      // Count is taken from the next busy vector so it stays in step with it.
      for (int unsigned i = 0; i < NREG; i++)
         ld_pending_d = ld_pending_d + (ADDR_W+1)'(busy_d[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q       <= '{default: '0};
         busy_q       <= '0;
         ld_pending_q <= '0;
         link_valid_q <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         ld_pending_q <= ld_pending_d;
         link_valid_q <= link_valid_d;
      end
   end

   // Read ports: bypass the same-cycle writeback; held at zero during reset so
   // a live writeback cannot leak through while the file is cleared.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      stall   = 1'b0;
      if (!rst) begin
         if (wb_en && wb_num == rs_num && rs_num != '0)
            rs_data = wb_data;
         else
            rs_data = regs_q[rs_num];

         if (wb_en && wb_num == rt_num && rt_num != '0)
            rt_data = wb_data;
         else
            rt_data = regs_q[rt_num];

         // A writeback this cycle resolves the hazard since the bypass
         // delivers the data.
         stall = (busy_q[rs_num] && rs_num != '0 && !(wb_en && wb_num == rs_num))
               | (busy_q[rt_num] && rt_num != '0 && !(wb_en && wb_num == rt_num));
      end
   end

   assign ld_pending = ld_pending_q;
   assign link_valid = link_valid_q;

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en;
   logic [4:0]  wb_num;
   logic [31:0] wb_data;
   logic [4:0]  rs_num, rt_num;
   logic [31:0] rs_data, rt_data;
   logic        ld_issue;
   logic [4:0]  ld_num;
   logic        flush;
   logic        stall;
   logic [5:0]  ld_pending;
   logic        link_valid;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   reg_file_wb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31)) dut (
      .clk(clk), .rst(rst),
      .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data),
      .rs_num(rs_num), .rt_num(rt_num),
      .rs_data(rs_data), .rt_data(rt_data),
      .ld_issue(ld_issue), .ld_num(ld_num), .flush(flush),
      .stall(stall), .ld_pending(ld_pending), .link_valid(link_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled
   // well away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wb_en = 1'b0; wb_num = '0; wb_data = '0;
      rs_num = '0; rt_num = '0; ld_issue = 1'b0; ld_num = '0; flush = 1'b0;
      #12;
      chk("rst_rs_data", rs_data, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_ld_pending", {26'b0, ld_pending}, 32'h0);
      chk("rst_link_valid", {31'b0, link_valid}, 32'h0);
      rst = 1'b0;
      step();

      // Write r5 with same-cycle bypass, then read back from the register.
      wb_en = 1'b1; wb_num = 5'd5; wb_data = 32'hDEADBEEF; rs_num = 5'd5; #1;
      chk("bypass_r5", rs_data, 32'hDEADBEEF);
      step();
      wb_en = 1'b0; #1;
      chk("stored_r5", rs_data, 32'hDEADBEEF);

      // Writes to r0 are discarded on both ports.
      wb_en = 1'b1; wb_num = 5'd0; wb_data = 32'h12345678; rs_num = 5'd0; rt_num = 5'd0; #1;
      chk("r0_rs_same", rs_data, 32'h0);
      chk("r0_rt_same", rt_data, 32'h0);
      step();
      wb_en = 1'b0; #1;
      chk("r0_rs_after", rs_data, 32'h0);
      chk("r0_rt_after", rt_data, 32'h0);

      // Load-use on r8 resolved by the writeback.
      ld_issue = 1'b1; ld_num = 5'd8;
      step();
      ld_issue = 1'b0; rt_num = 5'd8; #1;
      chk("ld8_stall", {31'b0, stall}, 32'h1);
      chk("ld8_pending", {26'b0, ld_pending}, 32'h1);
      wb_en = 1'b1; wb_num = 5'd8; wb_data = 32'h55; #1;
      chk("ld8_wb_stall", {31'b0, stall}, 32'h0);
      chk("ld8_wb_rt", rt_data, 32'h55);
      step();
      wb_en = 1'b0; #1;
      chk("ld8_done_pending", {26'b0, ld_pending}, 32'h0);
      chk("ld8_done_stall", {31'b0, stall}, 32'h0);
      chk("ld8_done_rt", rt_data, 32'h55);

      // Same-cycle set and clear of r8: set wins.
      ld_issue = 1'b1; ld_num = 5'd8;
      step();
      wb_en = 1'b1; wb_num = 5'd8; wb_data = 32'h66;
      step();
      ld_issue = 1'b0; wb_en = 1'b0; #1;
      chk("setclr_pending", {26'b0, ld_pending}, 32'h1);
      chk("setclr_stall", {31'b0, stall}, 32'h1);
      chk("setclr_rt", rt_data, 32'h66);

      // Same cycle again with flush: scoreboard empties, write still lands.
      ld_issue = 1'b1; ld_num = 5'd8; wb_en = 1'b1; wb_num = 5'd8; wb_data = 32'h77; flush = 1'b1;
      step();
      ld_issue = 1'b0; wb_en = 1'b0; flush = 1'b0; #1;
      chk("flush_pending", {26'b0, ld_pending}, 32'h0);
      chk("flush_stall", {31'b0, stall}, 32'h0);
      chk("flush_rt", rt_data, 32'h77);

      // Two outstanding loads, ld_num=0 ignored, hazard on either port.
      ld_issue = 1'b1; ld_num = 5'd3;
      step();
      ld_num = 5'd4;
      step();
      ld_num = 5'd0;
      step();
      ld_issue = 1'b0; rs_num = 5'd0; rt_num = 5'd4; #1;
      chk("two_pending", {26'b0, ld_pending}, 32'h2);
      chk("two_stall_rt", {31'b0, stall}, 32'h1);
      rs_num = 5'd3; rt_num = 5'd0; #1;
      chk("two_stall_rs", {31'b0, stall}, 32'h1);
      wb_en = 1'b1; wb_num = 5'd4; wb_data = 32'hAB;
      step();
      wb_en = 1'b0; #1;
      chk("one_pending", {26'b0, ld_pending}, 32'h1);
      flush = 1'b1;
      step();
      flush = 1'b0; #1;
      chk("flush2_pending", {26'b0, ld_pending}, 32'h0);
      chk("flush2_stall", {31'b0, stall}, 32'h0);

      // Link register write.
      chk("link_before", {31'b0, link_valid}, 32'h0);
      wb_en = 1'b1; wb_num = 5'd31; wb_data = 32'h41;
      step();
      wb_en = 1'b0; rs_num = 5'd31; rt_num = 5'd31; #1;
      chk("link_valid", {31'b0, link_valid}, 32'h1);
      chk("link_rs", rs_data, 32'h41);
      chk("link_rt", rt_data, 32'h41);
      step(); step();
      chk("link_sticky", {31'b0, link_valid}, 32'h1);

      // Independent ports: port A bypass while port B reads a stored value.
      wb_en = 1'b1; wb_num = 5'd7; wb_data = 32'hA5A5A5A5; rs_num = 5'd7; rt_num = 5'd5; #1;
      chk("mix_rs_bypass", rs_data, 32'hA5A5A5A5);
      chk("mix_rt_stored", rt_data, 32'hDEADBEEF);
      step();
      wb_en = 1'b0;

      // Reset mid-run between edges, with a live bypass and a live stall.
      ld_issue = 1'b1; ld_num = 5'd9;
      step();
      ld_issue = 1'b0; rs_num = 5'd9; rt_num = 5'd5;
      wb_en = 1'b1; wb_num = 5'd5; wb_data = 32'h99; #1;
      chk("pre_rst_stall", {31'b0, stall}, 32'h1);
      chk("pre_rst_rt", rt_data, 32'h99);
      #1 rst = 1'b1; #1;
      chk("mid_rst_rs", rs_data, 32'h0);
      chk("mid_rst_rt", rt_data, 32'h0);
      chk("mid_rst_stall", {31'b0, stall}, 32'h0);
      chk("mid_rst_pending", {26'b0, ld_pending}, 32'h0);
      chk("mid_rst_link", {31'b0, link_valid}, 32'h0);
      wb_en = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs_num = 5'(i); rt_num = 5'(31 - i); #1;
         chk("post_rst_rs", rs_data, 32'h0);
         chk("post_rst_rt", rt_data, 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
